fetch_sequencer: RTL and testbench

- Controls instruction fetch for the 5-stage pipeline; owns the fetch PC.
- Issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers one returned instruction while decode is stalled; flushes and redirects on an execute-stage branch or jump.
- Drives the IF/ID pipeline register directly: instruction, PC, PC+4 and a valid bit.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_sequencer_if.sv | 13 +
 rtl/fetch_hold_buf.sv | 39 +++
 rtl/fetch_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam logic [31:0] PC_INCR    = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus: one outstanding request at a time.
interface fetch_imem_if;
    import fetch_pkg::*;

    logic                  req;
    logic [FETCH_XLEN-1:0] addr;
    logic                  rvalid;
    logic [FETCH_XLEN-1:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding a returned instruction and its PC while decode stalls.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic                  clear_i,
    input  logic [FETCH_XLEN-1:0] instr_i,
    input  logic [FETCH_XLEN-1:0] pc_i,
    output logic                  valid_o,
    output logic [FETCH_XLEN-1:0] instr_o,
    output logic [FETCH_XLEN-1:0] pc_o
);

    logic                  valid_q;
    logic [FETCH_XLEN-1:0] instr_q;
    logic [FETCH_XLEN-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i || drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and IF/ID register driver; optional counters under FETCH_PERF_CNT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_d_i,
    fetch_imem_if.master    imem,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles_o,
    output logic [31:0]     perf_discards_o
`endif
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    if_id_t       out_q;

    logic         slot_free;
    logic         consume;
    logic [31:0]  pc_plus4;
    logic         req;
    logic [31:0]  req_addr;
    logic         buf_load;
    logic         buf_drain;
    logic         buf_clear;
    logic         drop;
    logic         buf_valid;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;

    assign consume   = out_q.valid & ~stall_d_i;
    assign slot_free = ~out_q.valid | consume;
    assign pc_plus4  = pc_q + PC_INCR;

    // Request is combinational so a response can chain straight into the next fetch.
    always_comb begin
        req       = 1'b0;
        req_addr  = pc_q;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_clear = 1'b0;
        drop      = 1'b0;
        case (state_q)
            BOOT: req = 1'b1;
            WAIT: begin
                if (imem.rvalid) begin
                    if (redirect_i) begin
                        req      = 1'b1;
                        req_addr = redirect_pc_i;
                        drop     = 1'b1;
                    end else if (slot_free) begin
                        req      = 1'b1;
                        req_addr = pc_plus4;
                    end else begin
                        buf_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    req       = 1'b1;
                    req_addr  = redirect_pc_i;
                    buf_clear = 1'b1;
                end else if (slot_free && buf_valid) begin
                    req       = 1'b1;
                    buf_drain = 1'b1;
                end
            end
            DISCARD: begin
                if (imem.rvalid) begin
                    req      = 1'b1;
                    req_addr = redirect_i ? redirect_pc_i : pc_q;
                    drop     = 1'b1;
                end
            end
            default: req = 1'b0;
        endcase
        if (rst) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            if (redirect_i) begin
                out_q.valid <= 1'b0;
            end else if (state_q == WAIT && imem.rvalid && slot_free) begin
                out_q <= '{valid: 1'b1, instr: imem.rdata, pc: pc_q, pc_plus4: pc_plus4};
            end else if (buf_drain) begin
                out_q <= '{valid: 1'b1, instr: buf_instr, pc: buf_pc, pc_plus4: buf_pc + PC_INCR};
            end else if (consume) begin
                out_q.valid <= 1'b0;
            end

            case (state_q)
                BOOT: begin
                    // A redirect here lands on top of the boot request, so its reply is stale.
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_i;
                        state_q <= DISCARD;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                        if (!imem.rvalid) begin
                            state_q <= DISCARD;
                        end
                    end else if (imem.rvalid) begin
                        pc_q <= pc_plus4;
                        if (!slot_free) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_i;
                        state_q <= WAIT;
                    end else if (buf_drain) begin
                        state_q <= WAIT;
                    end
                end
                DISCARD: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                    end
                    if (imem.rvalid) begin
                        state_q <= WAIT;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .clear_i (buf_clear),
        .instr_i (imem.rdata),
        .pc_i    (pc_q),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    assign imem.req      = req;
    assign imem.addr     = req_addr;
    assign if_valid_o    = out_q.valid;
    assign if_instr_o    = out_q.instr;
    assign if_pc_o       = out_q.pc;
    assign if_pc_plus4_o = out_q.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] discard_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            if (out_q.valid && stall_d_i && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (drop && discard_cnt_q != '1) begin
                discard_cnt_q <= discard_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles_o = stall_cnt_q;
    assign perf_discards_o     = discard_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, stall hold, redirects, reset and PC wrap.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        redir_a, redir_b;
    logic [31:0] rpc_a, rpc_b;
    logic        stall_a, stall_b;
    logic        valid_a, valid_b;
    logic [31:0] instr_a, pc_a, pc4_a;
    logic [31:0] instr_b, pc_b, pc4_b;
    int          checks = 0;
    int          failures = 0;

    fetch_imem_if ia ();
    fetch_imem_if ib ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pstall_a, pdisc_a, pstall_b, pdisc_b;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .redirect_i    (redir_a),
        .redirect_pc_i (rpc_a),
        .stall_d_i     (stall_a),
        .imem          (ia),
        .if_valid_o    (valid_a),
        .if_instr_o    (instr_a),
        .if_pc_o       (pc_a),
        .if_pc_plus4_o (pc4_a)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles_o (pstall_a),
        .perf_discards_o     (pdisc_a)
`endif
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .XLEN(32)) dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .redirect_i    (redir_b),
        .redirect_pc_i (rpc_b),
        .stall_d_i     (stall_b),
        .imem          (ib),
        .if_valid_o    (valid_b),
        .if_instr_o    (instr_b),
        .if_pc_o       (pc_b),
        .if_pc_plus4_o (pc4_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles_o (pstall_b),
        .perf_discards_o     (pdisc_b)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic redir, input logic [31:0] rpc, input logic stall,
                           input logic rv, input logic [31:0] rd);
        redir_a   = redir;
        rpc_a     = rpc;
        stall_a   = stall;
        ia.rvalid = rv;
        ia.rdata  = rd;
        #1;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        checks++;
        if (valid_a !== 1'b0 || instr_a !== 32'h0 || pc_a !== 32'h0 || pc4_a !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b i=%h pc=%h pc4=%h want all zero", valid_a, instr_a, pc_a, pc4_a);
        end
        checks++;
        if (ia.req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got %0b want 0", ia.req);
        end
        rst_a = 1'b0;
        #1;
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h0) begin
            failures++;
            $display("FAIL boot_req got req=%0b addr=%h want 1/00000000", ia.req, ia.addr);
        end
        cyc();
    endtask

    task automatic test_stream();
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h0));
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h4) begin
            failures++;
            $display("FAIL stream_req4 got req=%0b addr=%h want 1/00000004", ia.req, ia.addr);
        end
        cyc();
        checks++;
        if (valid_a !== 1'b1 || instr_a !== mem_word(32'h0) || pc_a !== 32'h0 || pc4_a !== 32'h4) begin
            failures++;
            $display("FAIL stream_out0 got v=%0b i=%h pc=%h pc4=%h want 1/%h/0/4", valid_a, instr_a, pc_a, pc4_a, mem_word(32'h0));
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h4));
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h8) begin
            failures++;
            $display("FAIL stream_req8 got req=%0b addr=%h want 1/00000008", ia.req, ia.addr);
        end
        cyc();
        checks++;
        if (valid_a !== 1'b1 || instr_a !== mem_word(32'h4) || pc_a !== 32'h4 || pc4_a !== 32'h8) begin
            failures++;
            $display("FAIL stream_out4 got v=%0b i=%h pc=%h pc4=%h want 1/%h/4/8", valid_a, instr_a, pc_a, pc4_a, mem_word(32'h4));
        end
    endtask

    task automatic test_stall_hold();
        drive_a(1'b0, 32'h0, 1'b1, 1'b1, mem_word(32'h8));
        checks++;
        if (ia.req !== 1'b0) begin
            failures++;
            $display("FAIL stall_noreq got %0b want 0", ia.req);
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (valid_a !== 1'b1 || pc_a !== 32'h4 || instr_a !== mem_word(32'h4) || ia.req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%0b pc=%h i=%h req=%0b want 1/4/%h/0", i, valid_a, pc_a, instr_a, ia.req, mem_word(32'h4));
            end
            cyc();
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'hC || pc_a !== 32'h4) begin
            failures++;
            $display("FAIL release_req got req=%0b addr=%h pc=%h want 1/0000000c/4", ia.req, ia.addr, pc_a);
        end
        cyc();
        checks++;
        if (valid_a !== 1'b1 || instr_a !== mem_word(32'h8) || pc_a !== 32'h8 || pc4_a !== 32'hC) begin
            failures++;
            $display("FAIL drain_out8 got v=%0b i=%h pc=%h pc4=%h want 1/%h/8/c", valid_a, instr_a, pc_a, pc4_a, mem_word(32'h8));
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'hC));
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h10) begin
            failures++;
            $display("FAIL req10 got req=%0b addr=%h want 1/00000010", ia.req, ia.addr);
        end
        cyc();
        checks++;
        if (valid_a !== 1'b1 || pc_a !== 32'hC) begin
            failures++;
            $display("FAIL out_c got v=%0b pc=%h want 1/0000000c", valid_a, pc_a);
        end
    endtask

    task automatic test_redirect_discard();
        drive_a(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++;
        if (ia.req !== 1'b0) begin
            failures++;
            $display("FAIL redir_noreq got %0b want 0", ia.req);
        end
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (valid_a !== 1'b0 || ia.req !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush got v=%0b req=%0b want 0/0", valid_a, ia.req);
        end
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h10));
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h100) begin
            failures++;
            $display("FAIL discard_req got req=%0b addr=%h want 1/00000100", ia.req, ia.addr);
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (valid_a !== 1'b0) begin
                failures++;
                $display("FAIL discard_idle%0d got v=%0b want 0", i, valid_a);
            end
            cyc();
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h100));
        checks++;
        if (valid_a !== 1'b0 || ia.req !== 1'b1 || ia.addr !== 32'h104) begin
            failures++;
            $display("FAIL target_req got v=%0b req=%0b addr=%h want 0/1/00000104", valid_a, ia.req, ia.addr);
        end
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (valid_a !== 1'b1 || pc_a !== 32'h100 || instr_a !== mem_word(32'h100) || pc4_a !== 32'h104) begin
            failures++;
            $display("FAIL target_out got v=%0b pc=%h i=%h pc4=%h want 1/100/%h/104", valid_a, pc_a, instr_a, pc4_a, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        cyc();
        cyc();
        drive_a(1'b1, 32'h200, 1'b0, 1'b1, mem_word(32'h104));
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h200) begin
            failures++;
            $display("FAIL samecyc_req got req=%0b addr=%h want 1/00000200", ia.req, ia.addr);
        end
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h200));
        checks++;
        if (valid_a !== 1'b0 || ia.req !== 1'b1 || ia.addr !== 32'h204) begin
            failures++;
            $display("FAIL samecyc_drop got v=%0b req=%0b addr=%h want 0/1/00000204", valid_a, ia.req, ia.addr);
        end
        cyc();
        checks++;
        if (valid_a !== 1'b1 || pc_a !== 32'h200 || instr_a !== mem_word(32'h200)) begin
            failures++;
            $display("FAIL samecyc_out got v=%0b pc=%h i=%h want 1/200/%h", valid_a, pc_a, instr_a, mem_word(32'h200));
        end
    endtask

    task automatic test_redirect_over_stall();
        drive_a(1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h204));
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_stall got v=%0b want 0", valid_a);
        end
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h300) begin
            failures++;
            $display("FAIL discard_req300 got req=%0b addr=%h want 1/00000300", ia.req, ia.addr);
        end
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (pstall_a !== 32'd4 || pdisc_a !== 32'd3) begin
            failures++;
            $display("FAIL perf_counts got stall=%0d disc=%0d want 4/3", pstall_a, pdisc_a);
        end
`endif
    endtask

    task automatic test_reset_mid_request();
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checks++;
        if (ia.req !== 1'b1 || ia.addr !== 32'h0 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_boot got req=%0b addr=%h v=%0b want 1/00000000/0", ia.req, ia.addr, valid_a);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (pstall_a !== 32'd0 || pdisc_a !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got stall=%0d disc=%0d want 0/0", pstall_a, pdisc_a);
        end
`endif
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b1, mem_word(32'h0));
        checks++;
        if (valid_a !== 1'b0 || ia.req !== 1'b1 || ia.addr !== 32'h4) begin
            failures++;
            $display("FAIL rst_stale got v=%0b req=%0b addr=%h want 0/1/00000004", valid_a, ia.req, ia.addr);
        end
        cyc();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (valid_a !== 1'b1 || pc_a !== 32'h0 || instr_a !== mem_word(32'h0)) begin
            failures++;
            $display("FAIL rst_first got v=%0b pc=%h i=%h want 1/0/%h", valid_a, pc_a, instr_a, mem_word(32'h0));
        end
    endtask

    task automatic test_pc_wrap();
        checks++;
        if (valid_b !== 1'b0 || ib.req !== 1'b0) begin
            failures++;
            $display("FAIL wrap_reset got v=%0b req=%0b want 0/0", valid_b, ib.req);
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (ib.req !== 1'b1 || ib.addr !== 32'hFFFF_FFF8) begin
            failures++;
            $display("FAIL wrap_boot got req=%0b addr=%h want 1/fffffff8", ib.req, ib.addr);
        end
        cyc();
        ib.rvalid = 1'b1;
        ib.rdata  = mem_word(32'hFFFF_FFF8);
        #1;
        checks++;
        if (ib.req !== 1'b1 || ib.addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_reqfc got req=%0b addr=%h want 1/fffffffc", ib.req, ib.addr);
        end
        cyc();
        ib.rdata = mem_word(32'hFFFF_FFFC);
        #1;
        checks++;
        if (pc_b !== 32'hFFFF_FFF8 || pc4_b !== 32'hFFFF_FFFC || ib.addr !== 32'h0 || ib.req !== 1'b1) begin
            failures++;
            $display("FAIL wrap_f8 got pc=%h pc4=%h req=%0b addr=%h want fffffff8/fffffffc/1/0", pc_b, pc4_b, ib.req, ib.addr);
        end
        cyc();
        ib.rdata = mem_word(32'h0);
        #1;
        checks++;
        if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC || pc4_b !== 32'h0 || instr_b !== mem_word(32'hFFFF_FFFC)) begin
            failures++;
            $display("FAIL wrap_fc got v=%0b pc=%h pc4=%h i=%h want 1/fffffffc/0/%h", valid_b, pc_b, pc4_b, instr_b, mem_word(32'hFFFF_FFFC));
        end
        cyc();
        ib.rvalid = 1'b0;
        checks++;
        if (pc_b !== 32'h0 || pc4_b !== 32'h4 || instr_b !== mem_word(32'h0)) begin
            failures++;
            $display("FAIL wrap_0 got pc=%h pc4=%h i=%h want 0/4/%h", pc_b, pc4_b, instr_b, mem_word(32'h0));
        end
    endtask

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        redir_a   = 1'b0;
        redir_b   = 1'b0;
        rpc_a     = 32'h0;
        rpc_b     = 32'h0;
        stall_a   = 1'b0;
        stall_b   = 1'b0;
        ia.rvalid = 1'b0;
        ia.rdata  = 32'h0;
        ib.rvalid = 1'b0;
        ib.rdata  = 32'h0;

        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_discard();
        test_redirect_same_cycle();
        test_redirect_over_stall();
        test_reset_mid_request();
        test_pc_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
